ceespu_int_ctrl: RTL
====================

CEESPU_INT_CTRL -- requirements
Module: ceespu_int_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of interrupt request channels, legal range 2..32.
REQ-002 Parameter VEC_W, default $clog2(NUM_IRQ): width of the vector index.
REQ-003 Parameter MASK_RST, default all ones (NUM_IRQ bits): reset value of the mask register.
REQ-004 I_clk  in  1  clock; all state changes on its rising edge.
REQ-005 I_rst  in  1  reset, synchronous, active-high.
REQ-006 I_irq  in  NUM_IRQ  raw interrupt request lines, synchronous to I_clk.
REQ-007 I_mask_we  in  1  write strobe for the mask register.
REQ-008 I_mask_data  in  NUM_IRQ  new mask value; 1 = channel enabled.
REQ-009 I_eint  in  1  decode retired an EINT instruction.
REQ-010 I_eint_val  in  1  EINT operand bit 0: 1 = enable, 0 = disable.
REQ-011 I_reti  in  1  decode retired a branch through c17 (handler return).
REQ-012 I_int_ack  in  1  decode accepted the interrupt (decode O_int_ack).
REQ-013 O_int  out  1  interrupt request to decode.
REQ-014 O_int_vector  out  VEC_W  index of the requested channel.
REQ-015 O_pending  out  NUM_IRQ  pending register.
REQ-016 O_mask  out  NUM_IRQ  mask register.
REQ-017 O_in_service  out  1  high while a handler runs.

Function
REQ-018 The block SHALL implement states IDLE, REQ and SERVICE, plus a global-enable flag gie.
REQ-019 In IDLE, when gie=1 and (O_pending & O_mask) != 0, the next state SHALL be REQ, with O_int_vector latched to the lowest-index active bit.
REQ-020 In REQ, O_int SHALL be 1, and O_int_vector SHALL stay frozen until acknowledgement, even if higher-priority bits arrive.
REQ-021 In REQ, I_int_ack=1 SHALL clear the vectored pending bit, set gie=0, and move to SERVICE in the same cycle.
REQ-022 In REQ, if a mask write disables the vectored channel before ack, the block SHALL drop O_int and return to IDLE on the next cycle.
REQ-023 In SERVICE, O_int SHALL be 0 and O_in_service SHALL be 1; new requests SHALL only accumulate in O_pending (no nesting).
REQ-024 In SERVICE, I_reti=1 or (I_eint=1 and I_eint_val=1) SHALL set gie=1 and move to IDLE.
REQ-025 I_eint=1 in IDLE or REQ SHALL load gie with I_eint_val; a load of 0 while in REQ SHALL drop O_int and return to IDLE.
REQ-026 When a channel's set event and its clear by ack fall in the same cycle, set SHALL win.
REQ-027 The mask register SHALL load I_mask_data on I_mask_we, with one cycle latency to the request logic.
REQ-028 Latency from a pending bit set in IDLE to O_int=1 SHALL be exactly 1 cycle.
REQ-029 I_int_ack outside REQ, and I_reti outside SERVICE, SHALL be ignored.

Reset
REQ-030 On I_rst=1 the block SHALL force the following values: state=IDLE, gie=1, O_pending=0, O_mask=MASK_RST, O_int=0, O_int_vector=0, O_in_service=0.
REQ-031 I_rst asserted in REQ or SERVICE SHALL abandon the request or service with no ack side effects.

Configuration
REQ-032 With CEESPU_INT_EDGE_EN defined, each channel SHALL set its pending bit on a 0->1 transition of I_irq (one-cycle registered previous value, reset 0), and the bit SHALL hold until ack clears it.
REQ-033 Without CEESPU_INT_EDGE_EN, O_pending SHALL equal the registered I_irq (level mode); ack SHALL NOT clear it, and the source SHALL deassert it.

Verification
REQ-034 Reset, then pulse I_irq[3] (edge mode) -> O_pending[3]=1 next cycle, O_int=1 one cycle later with vector 3; ack -> O_pending=0, O_in_service=1.
REQ-035 Raise I_irq[5] and I_irq[2] in the same cycle -> vector 2; after ack and I_reti -> vector 5 requested 1 cycle after returning to IDLE.
REQ-036 During SERVICE pulse I_irq[0] -> O_int stays 0, O_pending[0]=1; I_eint=1 with I_eint_val=1 -> O_int=1 with vector 0 one cycle after returning to IDLE.
REQ-037 In REQ with vector 4, write mask 0xEF -> O_int=0 next cycle, and no other channel is active.
REQ-038 Ack of channel 1 in the same cycle as a new edge on I_irq[1] -> O_pending[1] remains 1.
REQ-039 Assert I_rst in SERVICE -> O_in_service=0, gie=1, and O_mask equals MASK_RST the following cycle.

Source files
------------

// File: rtl/ceespu_int_ctrl.sv
// ============================================================================
//  Module      : ceespu_int_ctrl
//  Description : Vectored interrupt controller for the ceespu core. It keeps
//                a pending register and a mask register, and a global enable
//                (gie). It raises one request at a time towards decode with a
//                fixed lowest-index-first priority. Handlers do not nest: a
//                new request is raised only after the running handler has
//                returned through c17 (reti) or has executed EINT 1.
//  Options     : define CEESPU_INT_EDGE_EN to latch pending bits on rising
//                edges of I_irq. An acknowledge clears the latched bit.
//                When the macro is not defined, pending is a registered copy
//                of the level on I_irq.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ceespu_int_ctrl #(
  parameter int                 NUM_IRQ  = 8,
  parameter int                 VEC_W    = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0] MASK_RST = '1
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic               I_mask_we,
  input  logic [NUM_IRQ-1:0] I_mask_data,
  input  logic               I_eint,
  input  logic               I_eint_val,
  input  logic               I_reti,
  input  logic               I_int_ack,
  output logic               O_int,
  output logic [VEC_W-1:0]   O_int_vector,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic [NUM_IRQ-1:0] O_mask,
  output logic               O_in_service
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_gie;
  logic               w_gie_nxt;
  logic [VEC_W-1:0]   r_vector;
  logic [VEC_W-1:0]   w_vector_nxt;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] w_active;
  logic [VEC_W-1:0]   w_lowest;
  logic               w_any;
  logic               w_eint_off;
  logic               w_eint_on;
  logic               w_vec_masked;

  // The request logic sees the registered mask, so a mask write takes effect
  // one cycle after its strobe.
  assign w_active = r_pending & r_mask;
  assign w_any    = |w_active;

  // EINT 0 and EINT 1 decoded once and reused across states.
  assign w_eint_off = I_eint & ~I_eint_val;
  assign w_eint_on  = I_eint &  I_eint_val;

  // A mask write in flight that clears the channel currently being requested.
  assign w_vec_masked = I_mask_we & ~I_mask_data[r_vector];

  // Lowest-index active channel wins. The loop scans downward so that the
  // last assignment made is the lowest index.
  always_comb begin
    w_lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_lowest = VEC_W'(i);
      end
    end
  end

  // Next-state, gie and vector latch decisions for the request handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_gie_nxt    = r_gie;
    w_vector_nxt = r_vector;
    case (r_state)
      ST_IDLE: begin
        if (I_eint) begin
          w_gie_nxt = I_eint_val;
        end
        // An EINT 0 retiring in the same cycle blocks a request that would
        // otherwise start with interrupts already disabled.
        if (r_gie && !w_eint_off && w_any) begin
          w_state_nxt  = ST_REQ;
          w_vector_nxt = w_lowest;
        end
      end
      ST_REQ: begin
        // Decode's accept is final. It takes priority over any withdrawal
        // that arrives in the same cycle.
        if (I_int_ack) begin
          w_gie_nxt   = 1'b0;
          w_state_nxt = ST_SERVICE;
        end else if (w_eint_off) begin
          w_gie_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_eint_on) begin
            w_gie_nxt = 1'b1;
          end
          if (w_vec_masked) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_SERVICE: begin
        if (I_reti || w_eint_on) begin
          w_gie_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, gie and vector registers. Reset drops any request or handler that
  // is in progress and leaves no acknowledge side effects.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state  <= ST_IDLE;
      r_gie    <= 1'b1;
      r_vector <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gie    <= w_gie_nxt;
      r_vector <= w_vector_nxt;
    end
  end

  // Mask register, written directly by software.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_mask <= MASK_RST;
    end else if (I_mask_we) begin
      r_mask <= I_mask_data;
    end
  end

`ifdef CEESPU_INT_EDGE_EN
  localparam logic [NUM_IRQ-1:0] c_one = NUM_IRQ'(1);

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;

  assign w_set = I_irq & ~r_irq_prev;
  assign w_clr = (r_state == ST_REQ && I_int_ack) ? (c_one << r_vector) : '0;

  // Edge capture. The clear is applied before the set, so a new edge that
  // arrives with the acknowledge of the same channel is not lost.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
    end else begin
      r_irq_prev <= I_irq;
      r_pending  <= (r_pending & ~w_clr) | w_set;
    end
  end
`else
  // Level mode: pending follows the source one cycle later. Only the source
  // can withdraw a request.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= I_irq;
    end
  end
`endif

  assign O_int        = (r_state == ST_REQ);
  assign O_in_service = (r_state == ST_SERVICE);
  assign O_int_vector = r_vector;
  assign O_pending    = r_pending;
  assign O_mask       = r_mask;

endmodule

`default_nettype wire
